// File: rtl/program_loader_if.sv
// Host byte link and RAM write port between the loader and the system top.
// The loader acts as the slave of the byte stream and drives the write bus.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_mem_address;
  logic [31:0]           out_mem_data;
  logic                  out_mem_write;

  modport master (
    output in_byte,
    output in_valid,
    input  out_ready,
    input  out_mem_address,
    input  out_mem_data,
    input  out_mem_write
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    output out_ready,
    output out_mem_address,
    output out_mem_data,
    output out_mem_write
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: length header, big-endian payload words and
// an XOR checksum, written into RAM while the CPU is held in reset.
module program_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_WORDS  = 512,
  parameter int BASE_ADDR  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  program_loader_if.slave  bus,
  output logic             out_cpu_hold,
  output logic             out_done,
  output logic             out_error
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_ASM,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [1:0]            idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;

  logic        ready;
  logic        xfer;
  logic [15:0] len;

  assign ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_ASM)    || (state_q == S_CHECK);
  assign xfer  = bus.in_valid && ready;
  assign len   = {len_hi_q, bus.in_byte};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    len_hi_d = len_hi_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          state_d = S_LEN_HI;
          csum_d  = '0;
          addr_d  = BASE;
          idx_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_hi_d = bus.in_byte;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          cnt_d = len;
          if (len == 16'd0)
            state_d = S_CHECK;
          else if (len > 16'(MAX_WORDS))
            state_d = S_ERROR;
          else
            state_d = S_ASM;
        end
      end
      S_ASM: begin
        if (xfer) begin
          data_d = {data_q[23:0], bus.in_byte};
          csum_d = csum_q ^ bus.in_byte;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3)
            state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // address wraps freely past the top of RAM
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'd1;
        idx_d   = '0;
        state_d = (cnt_q == 16'd1) ? S_CHECK : S_ASM;
      end
      S_CHECK: begin
        if (xfer)
          state_d = (bus.in_byte == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= BASE;
      data_q   <= '0;
      cnt_q    <= '0;
      len_hi_q <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      len_hi_q <= len_hi_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
    end
  end

  assign bus.out_ready       = ready;
  assign bus.out_mem_address = addr_q;
  assign bus.out_mem_data    = data_q;
  assign bus.out_mem_write   = (state_q == S_WRITE);
  assign out_cpu_hold        = (state_q != S_DONE);
  assign out_done            = (state_q == S_DONE);
  assign out_error           = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: RAM writes are scored against a
// queue of expected {address, data} pairs filled as stimulus is driven.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_start = 1'b0;
  logic out_cpu_hold, out_done, out_error;

  int checks = 0;
  int failures = 0;

  logic [40:0] exp_q[$];

  program_loader_if #(.ADDR_WIDTH(9)) bus();

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_start     (in_start),
    .bus          (bus.slave),
    .out_cpu_hold (out_cpu_hold),
    .out_done     (out_done),
    .out_error    (out_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [40:0] obs,
                     input logic [40:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=%h expected=none",
               {bus.out_mem_address, bus.out_mem_data});
      end else begin
        chk("mem_write", {bus.out_mem_address, bus.out_mem_data},
            exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] xsum(input logic [7:0] s[$]);
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n = 0;
    bit acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (stall && $urandom_range(0, 1) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
      end
      acc = bus.in_valid && bus.out_ready;
      @(posedge clk);
      n++;
    end
    #1 bus.in_valid = 1'b0;
    if (!acc) chk("byte_timeout", 41'd0, 41'd1);
  endtask

  task automatic send_seq(input logic [7:0] s[$], input bit stall);
    foreach (s[i]) send_byte(s[i], stall);
  endtask

  task automatic pulse_start();
    @(negedge clk) in_start = 1'b1;
    @(negedge clk) in_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic chk_end(input string tag, input logic done, input logic err);
    chk({tag, "_done"}, 41'(out_done), 41'(done));
    chk({tag, "_error"}, 41'(out_error), 41'(err));
    chk({tag, "_hold"}, 41'(out_cpu_hold), 41'(!done));
    chk({tag, "_ready"}, 41'(bus.out_ready), 41'd0);
    chk({tag, "_pending"}, 41'(exp_q.size()), 41'd0);
  endtask

  logic [7:0] w1[$];
  logic [7:0] w2[$];
  logic [7:0] w3[$];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    w1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    w2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    w3 = '{8'h12, 8'h34, 8'h56, 8'h78};

    repeat (2) @(negedge clk);
    chk("rst_ready", 41'(bus.out_ready), 41'd0);
    chk("rst_write", 41'(bus.out_mem_write), 41'd0);
    chk("rst_addr", 41'(bus.out_mem_address), 41'd0);
    chk("rst_data", 41'(bus.out_mem_data), 41'd0);
    chk("rst_hold", 41'(out_cpu_hold), 41'd1);
    chk("rst_done", 41'(out_done), 41'd0);
    chk("rst_error", 41'(out_error), 41'd0);
    reset = 1'b0;

    // normal two-word load
    @(negedge clk);
    chk("idle_ready", 41'(bus.out_ready), 41'd0);
    pulse_start();
    exp_q.push_back({9'd0, 32'h11223344});
    exp_q.push_back({9'd1, 32'hAABBCCDD});
    send_seq('{8'h00, 8'h02}, 1'b0);
    send_seq(w1, 1'b0);
    send_seq(w2, 1'b0);
    send_byte(xsum(w1) ^ xsum(w2), 1'b0);
    chk_end("normal", 1'b1, 1'b0);
    pulse_start();
    chk_end("done_sticky", 1'b1, 1'b0);

    // zero length, good then bad checksum
    do_reset();
    pulse_start();
    send_seq('{8'h00, 8'h00, 8'h00}, 1'b0);
    chk_end("zero_ok", 1'b1, 1'b0);
    do_reset();
    pulse_start();
    send_seq('{8'h00, 8'h00, 8'h01}, 1'b0);
    chk_end("zero_bad", 1'b0, 1'b1);

    // oversize length
    do_reset();
    pulse_start();
    send_seq('{8'h02, 8'h01}, 1'b0);
    chk_end("oversize", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk_end("oversize_late", 1'b0, 1'b1);

    // checksum mismatch after one written word
    do_reset();
    pulse_start();
    exp_q.push_back({9'd0, 32'h12345678});
    send_seq('{8'h00, 8'h01}, 1'b0);
    send_seq(w3, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk_end("bad_sum", 1'b0, 1'b1);

    // stalled handshake with a stray start pulse mid-load
    do_reset();
    pulse_start();
    exp_q.push_back({9'd0, 32'h11223344});
    exp_q.push_back({9'd1, 32'hAABBCCDD});
    send_seq('{8'h00, 8'h02}, 1'b1);
    send_seq(w1, 1'b1);
    pulse_start();
    send_seq(w2, 1'b1);
    send_byte(xsum(w1) ^ xsum(w2), 1'b1);
    chk_end("stall", 1'b1, 1'b0);

    // reset during the second word, then a fresh one-word load
    do_reset();
    pulse_start();
    exp_q.push_back({9'd0, 32'h11223344});
    send_seq('{8'h00, 8'h02}, 1'b0);
    send_seq(w1, 1'b0);
    send_seq('{8'hAA, 8'hBB}, 1'b0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 41'(bus.out_ready), 41'd0);
    chk("mid_rst_write", 41'(bus.out_mem_write), 41'd0);
    chk("mid_rst_addr", 41'(bus.out_mem_address), 41'd0);
    chk("mid_rst_data", 41'(bus.out_mem_data), 41'd0);
    chk("mid_rst_hold", 41'(out_cpu_hold), 41'd1);
    chk("mid_rst_flags", 41'({out_done, out_error}), 41'd0);
    chk("mid_rst_pending", 41'(exp_q.size()), 41'd0);
    reset = 1'b0;
    pulse_start();
    exp_q.push_back({9'd0, 32'hDEADBEEF});
    send_seq('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 1'b0);
    chk_end("after_rst", 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
